road_painter: RTL and testbench
===============================

Name: road_painter

Overview:
- Full-frame pixel generator feeding the scrolling VGA stage: on each start pulse it sweeps every pixel of the 160x120 frame once, in raster order.
- Emits x, y, colour and plot, one pixel per clock, with a fixed road layout: grass, yellow edge lines, black tarmac and a dashed white centre stripe.
- The dash phase follows a latched scroll offset, so successive frames show the stripe moving.
- The downstream stage writes the pixels into the frame buffer.

Parameters:
- XSCREEN, 160, frame width in pixels
- YSCREEN, 120, frame height in pixels
- ROAD_LEFT, 40, x of the left yellow edge line
- ROAD_RIGHT, 119, x of the right yellow edge line
- LANE_X, 79, x of the first of two centre-stripe columns (LANE_X, LANE_X+1)
- DASH_LEN, 8, length in rows of one dash and of one gap; must be a power of two

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- start  in  1  frame request; single-cycle pulse or level
- scroll_offset  in  7  dash phase in rows; sampled only when a frame is accepted
- x  out  8  pixel column
- y  out  7  pixel row
- colour  out  3  {R,G,B}, 1 bit per channel
- plot  out  1  x/y/colour valid, write this pixel
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; latched offset=0.
- Reset asserted mid-frame aborts immediately: plot drops the same instant. There is no resume; a new start is required.
- All outputs are registered. x, y and colour change on the same edge, so colour always belongs to the x/y shown.
- FSM states: IDLE, DRAW, FINISH.
- IDLE, start=1 sampled at edge N:
  - Latch the offset: scroll_offset if it is < YSCREEN, else 0 (wrap rule).
  - Go to DRAW.
  - At edge N+1 the outputs show pixel (0,0) with plot=1, busy=1.
- DRAW:
  - One pixel per clock: x increments each cycle.
  - When x=XSCREEN-1: x wraps to 0 and y increments.
  - Pixel k (raster index) appears at edge N+1+k.
  - The last pixel (159,119) appears at edge N+19200.
- FINISH (entered at edge N+19201): plot=0, busy=0, done=1 for exactly one cycle; x and y return to 0. Next edge goes to IDLE.
- start is ignored in DRAW and FINISH; no queuing. The earliest accepted restart is sampled at edge N+19202.
- plot is high for exactly XSCREEN*YSCREEN = 19200 consecutive cycles per frame.
- Colour per pixel, highest priority first:
  1. x < ROAD_LEFT or x > ROAD_RIGHT: 3'b010 (green).
  2. x == ROAD_LEFT or x == ROAD_RIGHT: 3'b110 (yellow).
  3. x == LANE_X or x == LANE_X+1, with p = (y + offset) mod YSCREEN:
     - 3'b111 (white) if (p / DASH_LEN) is even;
     - else 3'b000.
  4. Otherwise: 3'b000 (black).
- Arithmetic for p:
  - y + offset is computed 8 bits wide (maximum 238).
  - Subtract YSCREEN once if the sum is >= YSCREEN; the result is always < 120.
  - The even/odd test is bit log2(DASH_LEN) of p.
- Colour is computed from the next x/y values and registered together with them; there is no extra pipeline bubble.

Decomposition:
- Package road_pkg:
  - XSCREEN/YSCREEN defaults;
  - colour constants C_GRASS, C_EDGE, C_STRIPE, C_TAR;
  - state enum {IDLE, DRAW, FINISH}.
- One combinational sub-module, road_pixel_colour: inputs x, y, offset; output colour. It holds the priority and dash arithmetic.
- The top level keeps the FSM, the counters and the output registers.

Test Plan:
- Reset: hold reset for 3 cycles -> x=0, y=0, colour=0, plot=0, busy=0, done=0. Release with start=0 -> outputs unchanged for 100 cycles.
- Full frame: start pulse at edge N, offset 0 -> (0,0) with plot at N+1; (159,0) at N+160; (0,1) at N+161; (159,119) at N+19200. plot count = 19200. done=1 only at N+19201; busy low after.
- Colours, offset 0:
  - (10,5) -> 010; (40,0) -> 110; (119,60) -> 110; (60,30) -> 000;
  - (79,0) -> 111; (80,7) -> 111; (79,8) -> 000; (79,16) -> 111.
  - Offset 4: (79,4) -> 000; (79,3) -> 111.
  - Offset 115: (79,5) -> p=0 -> 111; (79,13) -> p=8 -> 000.
- Offset ≥ YSCREEN: start with scroll_offset=125 -> identical to offset 0: (79,0) -> 111, (79,8) -> 000.
- Start while busy / offset change mid-frame:
  - Extra start pulses at N+500 and at the FINISH cycle -> ignored; exactly one done pulse; total plot count 19200.
  - Changing scroll_offset mid-frame -> stripe pattern unchanged until the next frame.
- Reset mid-frame: assert reset asynchronously at pixel 5000 -> plot/busy drop without waiting for a clock edge, no done pulse. A new start -> full 19200-pixel frame beginning at (0,0).

Source files
------------

// File: rtl/road_pkg.sv
// Shared road layout constants, colour codes and painter FSM states.
// Pure definitions; no timing or backpressure.
package road_pkg;

  localparam int XSCREEN    = 160;
  localparam int YSCREEN    = 120;
  localparam int ROAD_LEFT  = 40;
  localparam int ROAD_RIGHT = 119;
  localparam int LANE_X     = 79;
  localparam int DASH_LEN   = 8;
  localparam int DASH_BIT   = $clog2(DASH_LEN);

  localparam logic [2:0] C_GRASS  = 3'b010;
  localparam logic [2:0] C_EDGE   = 3'b110;
  localparam logic [2:0] C_STRIPE = 3'b111;
  localparam logic [2:0] C_TAR    = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // An out-of-range scroll offset restarts the dash phase from zero.
  function automatic logic [6:0] wrap_offset(input logic [6:0] off);
    return (off < 7'(YSCREEN)) ? off : 7'd0;
  endfunction

endpackage

// File: rtl/road_pixel_colour.sv
// Road colour for one pixel: grass, edge lines, dashed centre stripe, tarmac.
// Combinational, zero latency; no flow control.
module road_pixel_colour
  import road_pkg::*;
(
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [6:0] offset,
  output logic [2:0] colour
);

  logic [7:0] sum;
  logic [7:0] phase;

  always_comb begin
    sum   = {1'b0, y} + {1'b0, offset};
    // Both operands are < YSCREEN, so a single subtraction completes the modulo.
    phase = (sum >= 8'(YSCREEN)) ? sum - 8'(YSCREEN) : sum;

    if (x < 8'(ROAD_LEFT) || x > 8'(ROAD_RIGHT)) begin
      colour = C_GRASS;
    end else if (x == 8'(ROAD_LEFT) || x == 8'(ROAD_RIGHT)) begin
      colour = C_EDGE;
    end else if (x == 8'(LANE_X) || x == 8'(LANE_X + 1)) begin
      colour = (((phase >> DASH_BIT) & 8'd1) == 8'd0) ? C_STRIPE : C_TAR;
    end else begin
      colour = C_TAR;
    end
  end

endmodule

// File: rtl/road_painter.sv
// Sweeps the 160x120 frame in raster order, one registered pixel per clock after a start.
// First pixel one cycle after start is accepted; start is ignored while drawing or finishing.
module road_painter
  import road_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] scroll_offset,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t     state;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [6:0] offset;
  logic [2:0] pix_colour;

  // cx/cy name the pixel to be emitted on the next edge, so colour lines up with x/y.
  road_pixel_colour u_colour (
    .x      (cx),
    .y      (cy),
    .offset (offset),
    .colour (pix_colour)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cx     <= 8'd0;
      cy     <= 7'd0;
      offset <= 7'd0;
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            offset <= wrap_offset(scroll_offset);
            cx     <= 8'd0;
            cy     <= 7'd0;
            state  <= DRAW;
          end
        end

        DRAW: begin
          x      <= cx;
          y      <= cy;
          colour <= pix_colour;
          plot   <= 1'b1;
          busy   <= 1'b1;
          if (cx == 8'(XSCREEN - 1)) begin
            cx <= 8'd0;
            if (cy == 7'(YSCREEN - 1)) begin
              cy    <= 7'd0;
              state <= FINISH;
            end else begin
              cy <= cy + 7'd1;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end

        FINISH: begin
          x      <= 8'd0;
          y      <= 7'd0;
          colour <= 3'd0;
          plot   <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_road_painter.sv
// Randomised frame bench for road_painter against a raster/colour model built from the road rules.
module tb_road_painter;
  import road_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] scroll_offset = 7'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  road_painter dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .start         (start),
    .scroll_offset (scroll_offset),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .busy          (busy),
    .done          (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [2:0] ref_colour(input int px, input int py, input int off);
    if (px < ROAD_LEFT || px > ROAD_RIGHT) return 3'b010;
    if (px == ROAD_LEFT || px == ROAD_RIGHT) return 3'b110;
    if (px == LANE_X || px == LANE_X + 1)
      return ((((py + off) % YSCREEN) / DASH_LEN) % 2 == 0) ? 3'b111 : 3'b000;
    return 3'b000;
  endfunction

  // Expected vector layout: {x[7:0], y[6:0], colour[2:0], plot, busy, done}.
  task automatic check(input string tag, input logic [20:0] exp);
    logic [20:0] obs;
    obs = {x, y, colour, plot, busy, done};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed x=%0d y=%0d colour=%b plot=%b busy=%b done=%b, expected x=%0d y=%0d colour=%b plot=%b busy=%b done=%b",
             tag, obs[20:13], obs[12:6], obs[5:3], obs[2], obs[1], obs[0],
             exp[20:13], exp[12:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run_frame(input logic [6:0] off, input int abort_at);
    int eff;
    logic [20:0] exp;
    eff = (off < YSCREEN) ? int'(off) : 0;

    @(posedge CLOCK_50); #1;
    start = 1'b1;
    scroll_offset = off;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    scroll_offset = 7'($urandom);
    check("accept_cycle", 21'd0);

    for (int k = 0; k < XSCREEN * YSCREEN; k++) begin
      @(posedge CLOCK_50); #1;
      exp = {8'(k % XSCREEN), 7'(k / XSCREEN), ref_colour(k % XSCREEN, k / XSCREEN, eff), 3'b110};
      check($sformatf("pixel%0d_off%0d", k, off), exp);
      scroll_offset = 7'($urandom);
      // Extra requests mid-frame and during the FINISH state must be ignored.
      start = (k == 498) || (k == XSCREEN * YSCREEN - 1);
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1 check("async_abort", 21'd0);
        start = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 check("abort_held", 21'd0);
        reset = 1'b0;
        repeat (10) begin
          @(posedge CLOCK_50); #1;
          check("after_abort_idle", 21'd0);
        end
        return;
      end
    end

    @(posedge CLOCK_50); #1;
    start = 1'b0;
    check("done_pulse", 21'b001);
    repeat (20) begin
      @(posedge CLOCK_50); #1;
      check("idle_after_frame", 21'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1 check("reset_state", 21'd0);
    reset = 1'b0;
    repeat (100) begin
      @(posedge CLOCK_50); #1;
      scroll_offset = 7'($urandom);
      check("idle_no_start", 21'd0);
    end

    run_frame(7'd0, -1);
    run_frame(7'd125, -1);
    run_frame(7'($urandom_range(0, YSCREEN - 1)), 5000);
    run_frame(7'd115, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
